tc_pl_play_data_acprx: RTL and testbench
========================================

Name: tc_pl_play_data_acprx

Overview:
- ACP read-side counterpart of the capture write path.
- Fetches a contiguous block of 64-bit words from DDR through the ACP0 read channel in fixed-size bursts and buffers them in an internal FIFO.
- Streams the words to the playback/DAC datapath with a valid/ready handshake.
- Pulses completion once every requested word has been delivered downstream.

Parameters:
- CAP0_7, 32, DDR byte-address width
- CAP0_8, 32, CRC width
- LEN_W, 16, width of the word-count field
- BURST_BEATS, 16, maximum 64-bit beats per ACP read request (power of 2)
- FIFO_DEPTH, 64, internal FIFO depth in 64-bit words (power of 2, at least 2*BURST_BEATS)
- ARID, 3'd1, constant ID driven on every read request

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- tacp_en  in  1  start; rising edge sampled in IDLE only
- tacp_cmpt  out  1  one-cycle pulse when the transfer is finished
- busy  out  1  high from accepted start until tacp_cmpt
- play_addr  in  CAP0_7  DDR base address; low 7 bits forced to 0
- play_words  in  LEN_W  number of 64-bit words to fetch
- play_crc32  out  CAP0_8  CRC32 of fetched data (optional feature)
- rx_err  out  1  sticky error flag; cleared on start and on rst
- acp0_rx_en  out  1  read request valid
- acp0_rx_rdy  in  1  request accepted when high together with acp0_rx_en
- acp0_rx_araddr  out  32  burst start address
- acp0_rx_arid  out  3  request ID
- acp0_rx_arlen  out  8  beats in this burst minus 1
- acp0_rx_rdata  in  64  read data beat
- acp0_rx_rdvld  in  1  read data beat valid
- dout  out  64  stream data (FIFO head)
- dout_valid  out  1  FIFO not empty
- dout_ready  in  1  downstream accepts dout this cycle

Behaviour:
- Reset values: all outputs 0, FIFO flushed, state IDLE, all counters 0. Reset mid-transfer aborts immediately. Beats arriving after reset are ignored until the next start.
- Start condition: IDLE plus tacp_en rising edge (tacp_en registered).
  - Latch base = {play_addr[31:7], 7'b0}.
  - Latch remaining_req = play_words and remaining_out = play_words.
  - Clear rx_err and the CRC.
  - Set busy.
  - If play_words == 0, go to DONE.
- FSM states: IDLE, REQ, DATA, DRAIN, DONE.
- REQ:
  - blen = min(BURST_BEATS, remaining_req).
  - Assert acp0_rx_en only when FIFO free slots >= blen. Free space is counted from both committed entries and outstanding reservations.
  - araddr = base + issued_words*8. arlen = blen-1. arid = ARID.
  - Request fields are stable while acp0_rx_en is high.
  - On en && rdy: reserve blen slots, remaining_req -= blen, go to DATA.
- DATA:
  - Each rdvld beat is written to the FIFO and the beat counter increments.
  - After blen beats: if remaining_req != 0, go to REQ; else go to DRAIN.
  - Only one request is outstanding at a time.
- DRAIN: wait until remaining_out == 0, then go to DONE.
- DONE: tacp_cmpt high for exactly one cycle, busy low, go to IDLE.
- Output side (all states):
  - dout_valid = FIFO non-empty.
  - Pop on dout_valid && dout_ready; each pop decrements remaining_out.
  - dout is registered FIFO data with zero-bubble output: back-to-back pops sustain 1 word/cycle.
- Simultaneous push and pop in the same cycle: occupancy unchanged. Pop on full and push on empty are both legal.
- Error and boundary handling:
  - rdvld outside DATA, or beyond blen: beat dropped, rx_err set.
  - rdvld when the FIFO is physically full (cannot occur with correct reservation): beat dropped, rx_err set.
- tacp_en held high or toggled while busy: ignored. A new start requires a fresh rising edge in IDLE.
- Address wrap: araddr wraps modulo 2^32. Bursts never cross a 4 KB boundary because the base is 128-byte aligned and BURST_BEATS*8 <= 128.
- Latency: first acp0_rx_en 2 cycles after the tacp_en edge (edge register plus state register). First dout_valid 1 cycle after the first rdvld.

Optional Feature:
- Macro: TC_PL_PLAY_CRC_EN.
- Defined:
  - play_crc32 = CRC-32 (poly 0x04C11DB7, init 0xFFFFFFFF, reflected in/out, final XOR 0xFFFFFFFF) over every accepted FIFO push, 8 bytes per beat, byte 0 = rdata[7:0].
  - Updated in the push cycle; valid when tacp_cmpt pulses.
  - Held until the next start.
- Not defined: play_crc32 tied to 0; no CRC logic synthesised.

Test Plan:
- play_addr=0x1000_0055, play_words=40, dout_ready=1, memory returns beats immediately.
  - Expect 3 requests: araddr 0x1000_0000/0x1000_0080/0x1000_0100, arlen 15/15/7, arid 1.
  - Expect 40 words in order and one tacp_cmpt pulse.
- play_words=0 -> no acp0_rx_en, tacp_cmpt 3 cycles after the tacp_en edge, busy low afterwards.
- dout_ready=0 throughout, play_words=200 -> exactly 64 words pushed (4 bursts), then acp0_rx_en held low.
  - Raise dout_ready: fetching resumes, all 200 words delivered, no rx_err.
- Extra rdvld beat injected after a 16-beat burst -> beat not in stream, rx_err=1. Next start clears rx_err.
- rst asserted while in DATA mid-burst -> all outputs 0 next cycle. A subsequent clean start of 8 words completes correctly.
- TC_PL_PLAY_CRC_EN defined, 2 words 0x0706050403020100 and 0x0F0E0D0C0B0A0908 -> play_crc32 = CRC-32 of bytes 0x00..0x0F = 0xCECEE288 at tacp_cmpt.

Source files
------------

// File: rtl/tc_pl_play_data_acprx.sv
// tc_pl_play_data_acprx: ACP0 read-side playback fetcher (DDR bursts -> local FIFO -> dout stream).
// Define TC_PL_PLAY_CRC_EN to compute a CRC-32 of every accepted beat on play_crc32.
module tc_pl_play_data_acprx #(
    parameter int         CAP0_7      = 32,
    parameter int         CAP0_8      = 32,
    parameter int         LEN_W       = 16,
    parameter int         BURST_BEATS = 16,
    parameter int         FIFO_DEPTH  = 64,
    parameter logic [2:0] ARID        = 3'd1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tacp_en,
    output logic              tacp_cmpt,
    output logic              busy,
    input  logic [CAP0_7-1:0] play_addr,
    input  logic [LEN_W-1:0]  play_words,
    output logic [CAP0_8-1:0] play_crc32,
    output logic              rx_err,
    output logic              acp0_rx_en,
    input  logic              acp0_rx_rdy,
    output logic [31:0]       acp0_rx_araddr,
    output logic [2:0]        acp0_rx_arid,
    output logic [7:0]        acp0_rx_arlen,
    input  logic [63:0]       acp0_rx_rdata,
    input  logic              acp0_rx_rdvld,
    output logic [63:0]       dout,
    output logic              dout_valid,
    input  logic              dout_ready
);
    // state | meaning
    // IDLE  | waiting for a tacp_en rising edge
    // REQ   | burst request waiting for FIFO space and acp0_rx_rdy
    // DATA  | collecting the beats of the single outstanding burst
    // DRAIN | everything fetched, downstream still taking words
    // DONE  | one-cycle completion

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BEAT_W = $clog2(BURST_BEATS) + 1;

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_DATA, S_DRAIN, S_DONE} state_t;
    state_t state_q, state_d;

    logic              en_q, edge_q, start;
    logic [CAP0_7-1:0] base_q;
    logic [LEN_W-1:0]  rem_req_q, rem_out_q, issued_q;
    logic [BEAT_W-1:0] blen, blen_q, beat_cnt_q;
    logic [CNT_W-1:0]  count_q, resv_q, free;
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [63:0]       mem [FIFO_DEPTH];
    logic              push, pop, req_fire, last_beat;
    logic              unused_addr_lsb;

    assign unused_addr_lsb = ^play_addr[6:0];

    assign start = (state_q == S_IDLE) && edge_q;
    assign blen  = (rem_req_q >= LEN_W'(BURST_BEATS)) ? BEAT_W'(BURST_BEATS) : BEAT_W'(rem_req_q);
    // Free space excludes slots already promised to the outstanding burst.
    assign free  = CNT_W'(FIFO_DEPTH) - count_q - resv_q;

    assign acp0_rx_en     = (state_q == S_REQ) && (free >= CNT_W'(blen));
    assign acp0_rx_araddr = (state_q == S_REQ) ? 32'(base_q + CAP0_7'({issued_q, 3'b000})) : 32'd0;
    assign acp0_rx_arlen  = (state_q == S_REQ) ? (8'(blen) - 8'd1) : 8'd0;
    assign acp0_rx_arid   = (state_q == S_REQ) ? ARID : 3'd0;
    assign req_fire       = acp0_rx_en && acp0_rx_rdy;

    assign push = (state_q == S_DATA) && acp0_rx_rdvld && (beat_cnt_q < blen_q)
                  && (count_q != CNT_W'(FIFO_DEPTH));
    assign last_beat  = push && ((beat_cnt_q + BEAT_W'(1)) == blen_q);
    assign dout_valid = (count_q != '0);
    assign pop        = dout_valid && dout_ready;
    assign dout       = dout_valid ? mem[rd_ptr_q] : 64'd0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = (play_words == '0) ? S_DONE : S_REQ;
            S_REQ:   if (req_fire) state_d = S_DATA;
            S_DATA:  if (last_beat) state_d = (rem_req_q != '0) ? S_REQ : S_DRAIN;
            S_DRAIN: if (rem_out_q == '0) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            en_q       <= 1'b0;
            edge_q     <= 1'b0;
            tacp_cmpt  <= 1'b0;
            busy       <= 1'b0;
            rx_err     <= 1'b0;
            base_q     <= '0;
            rem_req_q  <= '0;
            rem_out_q  <= '0;
            issued_q   <= '0;
            blen_q     <= '0;
            beat_cnt_q <= '0;
            resv_q     <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            en_q      <= tacp_en;
            edge_q    <= tacp_en && !en_q;
            state_q   <= state_d;
            tacp_cmpt <= (state_q == S_DONE);
            if (start)                  busy <= 1'b1;
            else if (state_q == S_DONE) busy <= 1'b0;

            if (start) begin
                base_q    <= {play_addr[CAP0_7-1:7], 7'b0};
                rem_req_q <= play_words;
                rem_out_q <= play_words;
                issued_q  <= '0;
                rx_err    <= 1'b0;
            end else begin
                if (req_fire) begin
                    rem_req_q  <= rem_req_q - LEN_W'(blen);
                    issued_q   <= issued_q + LEN_W'(blen);
                    blen_q     <= blen;
                    beat_cnt_q <= '0;
                    resv_q     <= CNT_W'(blen);
                end else if (push) begin
                    beat_cnt_q <= beat_cnt_q + BEAT_W'(1);
                    resv_q     <= resv_q - CNT_W'(1);
                end
                if (pop && rem_out_q != '0) rem_out_q <= rem_out_q - LEN_W'(1);
                // Stale beats seen in IDLE (e.g. after an abort) are dropped silently.
                if (acp0_rx_rdvld && !push && state_q != S_IDLE) rx_err <= 1'b1;
            end

            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= acp0_rx_rdata;
    end

`ifdef TC_PL_PLAY_CRC_EN
    logic [31:0] crc_q;

    // Reflected CRC-32, LSB of byte 0 first.
    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [63:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 64; i++)
            r = (r >> 1) ^ (((r[0] ^ d[i]) != 1'b0) ? 32'hEDB8_8320 : 32'h0);
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst || start) crc_q <= 32'hFFFF_FFFF;
        else if (push)    crc_q <= crc_step(crc_q, acp0_rx_rdata);
    end

    assign play_crc32 = CAP0_8'(~crc_q);
`else
    assign play_crc32 = '0;
`endif

endmodule

// File: tb/tb_tc_pl_play_data_acprx.sv
// tb_tc_pl_play_data_acprx: randomized bench with a DDR responder and a word/request
// reference model for tc_pl_play_data_acprx.
module tb_tc_pl_play_data_acprx;

    logic        clk = 1'b0;
    logic        rst, tacp_en, tacp_cmpt, busy, rx_err;
    logic [31:0] play_addr, play_crc32;
    logic [15:0] play_words;
    logic        acp0_rx_en, acp0_rx_rdy, acp0_rx_rdvld;
    logic [31:0] acp0_rx_araddr;
    logic [2:0]  acp0_rx_arid;
    logic [7:0]  acp0_rx_arlen;
    logic [63:0] acp0_rx_rdata, dout;
    logic        dout_valid, dout_ready;

    always #5 clk = ~clk;

    tc_pl_play_data_acprx dut (
        .clk(clk), .rst(rst), .tacp_en(tacp_en), .tacp_cmpt(tacp_cmpt), .busy(busy),
        .play_addr(play_addr), .play_words(play_words), .play_crc32(play_crc32),
        .rx_err(rx_err), .acp0_rx_en(acp0_rx_en), .acp0_rx_rdy(acp0_rx_rdy),
        .acp0_rx_araddr(acp0_rx_araddr), .acp0_rx_arid(acp0_rx_arid),
        .acp0_rx_arlen(acp0_rx_arlen), .acp0_rx_rdata(acp0_rx_rdata),
        .acp0_rx_rdvld(acp0_rx_rdvld), .dout(dout), .dout_valid(dout_valid),
        .dout_ready(dout_ready)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model state
    logic [63:0] exp_words[$];
    logic [39:0] exp_req[$];
    logic [63:0] resp_q[$];
    logic [31:0] exp_crc, crc_at_cmpt;
    int  cyc, first_en, cmpt_cyc, cmpt_cnt, beats_driven, en_cycles, retoggle_at, ready_hold;
    int  ready_prob, rdy_prob, beat_prob;
    bit  inject, extra_pending, pattern_mode;

    function automatic logic [63:0] mem_word(input logic [31:0] a);
        logic [63:0] w;
        if (pattern_mode) begin
            for (int j = 0; j < 8; j++) w[8*j +: 8] = 8'(a + 32'(j));
        end else begin
            w = {a ^ 32'h5A5A_C3C3, a * 32'h9E37_79B1};
        end
        return w;
    endfunction

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        return r;
    endfunction

    task automatic tick();
        logic [39:0] r;
        @(negedge clk);
        cyc++;
        tacp_en = (en_cycles > 0) || (cyc == retoggle_at);
        if (en_cycles > 0) en_cycles--;
        acp0_rx_rdy = ($urandom_range(99) < rdy_prob);
        dout_ready  = (cyc >= ready_hold) && ($urandom_range(99) < ready_prob);
        if (extra_pending) begin
            acp0_rx_rdvld = 1'b1;
            acp0_rx_rdata = 64'hDEAD_BEEF_0BAD_F00D;
            extra_pending = 1'b0;
        end else if (resp_q.size() > 0 && $urandom_range(99) < beat_prob) begin
            acp0_rx_rdvld = 1'b1;
            acp0_rx_rdata = resp_q.pop_front();
            beats_driven++;
            if (inject && resp_q.size() == 0 && exp_req.size() == 0) begin
                extra_pending = 1'b1;
                inject = 1'b0;
            end
        end else begin
            acp0_rx_rdvld = 1'b0;
            acp0_rx_rdata = {$urandom, $urandom};
        end
        #1;
        if (cyc == 2) begin
            chk("busy_after_start", 64'(busy), 64'd1);
            chk("err_clr_on_start", 64'(rx_err), 64'd0);
        end
        if (acp0_rx_en && first_en < 0) first_en = cyc;
        if (acp0_rx_en && acp0_rx_rdy) begin
            if (exp_req.size() == 0) begin
                chk("req_unexpected", 64'(acp0_rx_araddr), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                r = exp_req.pop_front();
                chk("araddr", 64'(acp0_rx_araddr), 64'(r[39:8]));
                chk("arlen", 64'(acp0_rx_arlen), 64'(r[7:0]));
                chk("arid", 64'(acp0_rx_arid), 64'd1);
            end
            for (int i = 0; i <= int'(acp0_rx_arlen); i++)
                resp_q.push_back(mem_word(acp0_rx_araddr + 32'(8 * i)));
        end
        if (dout_valid && dout_ready) begin
            if (exp_words.size() == 0) chk("dout_unexpected", 64'(dout_valid), 64'd0);
            else                       chk("dout", dout, exp_words.pop_front());
        end
        if (ready_hold > 0 && cyc == ready_hold - 1) begin
            chk("bp_pushes", 64'(beats_driven), 64'd64);
            chk("bp_en_low", 64'(acp0_rx_en), 64'd0);
            chk("bp_valid", 64'(dout_valid), 64'd1);
        end
        if (tacp_cmpt) begin
            cmpt_cnt++;
            cmpt_cyc    = cyc;
            crc_at_cmpt = play_crc32;
        end
    endtask

    task automatic prep(input logic [31:0] addr, input int words, input int en_len,
                        input int retog, input int rp, input int qp, input int bp,
                        input int hold, input bit inj);
        logic [31:0] base;
        logic [63:0] w;
        int rem, k, bl;
        base = {addr[31:7], 7'b0};
        exp_req.delete(); exp_words.delete(); resp_q.delete();
        rem = words; k = 0;
        while (rem > 0) begin
            bl = (rem > 16) ? 16 : rem;
            exp_req.push_back({base + 32'(128 * k), 8'(bl - 1)});
            rem -= bl; k++;
        end
        exp_crc = 32'hFFFF_FFFF;
        for (int i = 0; i < words; i++) begin
            w = mem_word(base + 32'(8 * i));
            exp_words.push_back(w);
            for (int j = 0; j < 8; j++) exp_crc = crc_byte(exp_crc, w[8*j +: 8]);
        end
        exp_crc = ~exp_crc;
        play_addr = addr; play_words = 16'(words);
        ready_prob = rp; rdy_prob = qp; beat_prob = bp; ready_hold = hold;
        cyc = -1; first_en = -1; cmpt_cnt = 0; cmpt_cyc = -1; beats_driven = 0;
        en_cycles = en_len; retoggle_at = retog; inject = inj; extra_pending = 1'b0;
    endtask

    task automatic run_xfer(input logic [31:0] addr, input int words, input int en_len,
                            input int retog, input int rp, input int qp, input int bp,
                            input int hold, input bit inj, input bit exp_err);
        int budget;
        prep(addr, words, en_len, retog, rp, qp, bp, hold, inj);
        budget = 60 * words + hold + 100;
        while (cmpt_cnt == 0 && cyc < budget) tick();
        if (cmpt_cnt == 0) chk("timeout", 64'(cyc), 64'(-1));
        repeat (4) tick();
        chk("cmpt_pulses", 64'(cmpt_cnt), 64'd1);
        chk("words_left", 64'(exp_words.size()), 64'd0);
        chk("reqs_left", 64'(exp_req.size()), 64'd0);
        chk("busy_end", 64'(busy), 64'd0);
        chk("rx_err_end", 64'(rx_err), 64'(exp_err));
        if (words == 0) begin
            chk("zero_no_req", 64'(first_en < 0), 64'd1);
            chk("zero_cmpt_lat", 64'(cmpt_cyc), 64'd3);
        end else begin
            chk("first_req_lat", 64'(first_en), 64'd2);
        end
`ifdef TC_PL_PLAY_CRC_EN
        chk("crc", 64'(crc_at_cmpt), 64'(exp_crc));
`else
        chk("crc_tied0", 64'(crc_at_cmpt), 64'd0);
`endif
    endtask

    initial begin
        int w, el;
        logic [31:0] a;
        rst = 1'b1; tacp_en = 1'b0; play_addr = '0; play_words = '0;
        acp0_rx_rdy = 1'b0; acp0_rx_rdvld = 1'b0; acp0_rx_rdata = '0; dout_ready = 1'b0;
        pattern_mode = 1'b0; exp_crc = '0; crc_at_cmpt = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ctrl", 64'({tacp_cmpt, busy, rx_err, acp0_rx_en, dout_valid}), 64'd0);
        chk("rst_req", 64'({acp0_rx_araddr, acp0_rx_arid, acp0_rx_arlen}), 64'd0);
        chk("rst_dout", dout, 64'd0);
        chk("rst_crc", 64'(play_crc32), 64'd0);
        rst = 1'b0;

        run_xfer(32'h1000_0055, 40, 1, -1, 100, 100, 100, 0, 1'b0, 1'b0);
        run_xfer(32'h2000_0000, 0, 1, -1, 100, 100, 100, 0, 1'b0, 1'b0);
        run_xfer(32'h3000_0040, 200, 1, 2, 100, 100, 100, 120, 1'b0, 1'b0);
        run_xfer(32'h4000_0000, 16, 1, -1, 100, 100, 100, 0, 1'b1, 1'b1);
        run_xfer(32'h4000_1000, 20, 2, 3, 70, 60, 80, 0, 1'b0, 1'b0);

        // Abort in the middle of the first burst
        prep(32'h5000_0000, 40, 1, -1, 100, 100, 100, 0, 1'b0);
        while (beats_driven < 5 && cyc < 200) tick();
        chk("abort_reached_data", 64'(beats_driven), 64'd5);
        @(negedge clk);
        rst = 1'b1; acp0_rx_rdvld = 1'b0; tacp_en = 1'b0; dout_ready = 1'b0;
        @(negedge clk);
        #1;
        chk("abort_ctrl", 64'({tacp_cmpt, busy, rx_err, acp0_rx_en, dout_valid}), 64'd0);
        chk("abort_req", 64'({acp0_rx_araddr, acp0_rx_arid, acp0_rx_arlen}), 64'd0);
        chk("abort_dout", dout, 64'd0);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            acp0_rx_rdvld = 1'b1; acp0_rx_rdata = {$urandom, $urandom};
        end
        @(negedge clk);
        acp0_rx_rdvld = 1'b0;
        #1;
        chk("stale_beats_dropped", 64'(dout_valid), 64'd0);
        chk("stale_no_req", 64'(acp0_rx_en), 64'd0);
        run_xfer(32'h5000_0200, 8, 1, -1, 100, 100, 100, 0, 1'b0, 1'b0);

        for (int it = 0; it < 8; it++) begin
            a  = ($urandom_range(3) == 0) ? (32'hFFFF_FF00 | 32'($urandom_range(127))) : $urandom;
            w  = $urandom_range(1, 150);
            el = $urandom_range(1, 2);
            run_xfer(a, w, el, ($urandom_range(1) == 1) ? el + 1 : -1,
                     $urandom_range(30, 100), $urandom_range(30, 100), $urandom_range(30, 100),
                     0, 1'b0, 1'b0);
        end

`ifdef TC_PL_PLAY_CRC_EN
        pattern_mode = 1'b1;
        run_xfer(32'h0000_0000, 2, 1, -1, 100, 100, 100, 0, 1'b0, 1'b0);
        chk("crc_known_vector", 64'(crc_at_cmpt), 64'h0000_0000_CECE_E288);
        pattern_mode = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
